// File: rtl/button_bounce_if.sv
// Handshake and button line between a test sequencer and the bounce generator.
interface button_bounce_if;
  logic start;
  logic level;
  logic ready;
  logic busy;
  logic done;
  logic button;

  modport master (output start, level, input ready, busy, done, button);
  modport slave  (input start, level, output ready, busy, done, button);
endinterface

// File: rtl/button_bounce_gen.sv
// Synthetic switch waveform: clean edge, glitch train, stable hold, one-cycle done.
// start is only taken while ready; requests during a transition are dropped, not queued.
module button_bounce_gen #(
  parameter int          BOUNCE_GLITCHES   = 3,
  parameter int          MAX_BOUNCE_CYCLES = 4,
  parameter int          HOLD_CYCLES       = 16,
  parameter int          RANDOM            = 1,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input logic            clk,
  input logic            reset,
  button_bounce_if.slave bb
);

  localparam int LW = $clog2(MAX_BOUNCE_CYCLES);
  localparam int CW = $clog2(MAX_BOUNCE_CYCLES + HOLD_CYCLES + 1);
  localparam int GW = $clog2(BOUNCE_GLITCHES + 1) + 1;

  typedef enum logic [2:0] {IDLE, SEG_ON, SEG_OFF, HOLD, DONE} state_t;

  state_t         state, state_nxt;
  logic           target;
  logic           button_q;
  logic [CW-1:0]  cnt;
  logic [GW-1:0]  gcnt;
  logic [15:0]    lfsr;
  logic [15:0]    lfsr_nxt;
  logic [CW-1:0]  seg_load;
  logic [CW-1:0]  hold_load;
  logic           seg_end;
  logic           glitchy;
  logic           more_glitches;

  // Counters hold "cycles remaining minus one", so a segment ends when cnt hits zero.
  assign lfsr_nxt      = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign seg_load      = (RANDOM != 0) ? CW'(lfsr[LW-1:0]) : CW'(MAX_BOUNCE_CYCLES - 1);
  assign hold_load     = CW'(HOLD_CYCLES - 1);
  assign seg_end       = (cnt == '0);
  assign glitchy       = (BOUNCE_GLITCHES > 0) && (bb.level != button_q);
  assign more_glitches = (int'(gcnt) < BOUNCE_GLITCHES);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bb.start) state_nxt = glitchy ? SEG_ON : HOLD;
      SEG_ON:  if (seg_end)  state_nxt = more_glitches ? SEG_OFF : HOLD;
      SEG_OFF: if (seg_end)  state_nxt = SEG_ON;
      HOLD:    if (seg_end)  state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // The LFSR steps only when a new segment length is loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      target   <= 1'b0;
      button_q <= 1'b0;
      cnt      <= '0;
      gcnt     <= '0;
      lfsr     <= LFSR_SEED;
    end else begin
      case (state)
        IDLE: begin
          if (bb.start) begin
            target   <= bb.level;
            button_q <= bb.level;
            gcnt     <= '0;
            if (glitchy) begin
              cnt  <= seg_load;
              lfsr <= lfsr_nxt;
            end else begin
              cnt  <= hold_load;
            end
          end
        end
        SEG_ON: begin
          if (!seg_end) begin
            cnt <= cnt - 1'b1;
          end else if (more_glitches) begin
            button_q <= ~target;
            cnt      <= seg_load;
            lfsr     <= lfsr_nxt;
          end else begin
            cnt <= hold_load;
          end
        end
        SEG_OFF: begin
          if (!seg_end) begin
            cnt <= cnt - 1'b1;
          end else begin
            button_q <= target;
            gcnt     <= gcnt + 1'b1;
            cnt      <= seg_load;
            lfsr     <= lfsr_nxt;
          end
        end
        HOLD: begin
          if (!seg_end) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bb.ready  = (state == IDLE);
    bb.busy   = (state != IDLE);
    bb.done   = (state == DONE);
    bb.button = button_q;
  end

endmodule

// File: tb/tb_button_bounce_gen.sv
// Scoreboarded bench: a deterministic and a randomized generator against a waveform model.
module tb_button_bounce_gen;
  localparam int          G    = 2;
  localparam int          M    = 4;
  localparam int          H    = 5;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  button_bounce_if bi0 ();
  button_bounce_if bi1 ();

  button_bounce_gen #(.BOUNCE_GLITCHES(G), .MAX_BOUNCE_CYCLES(M), .HOLD_CYCLES(H),
                      .RANDOM(0), .LFSR_SEED(SEED)) dut_det (.clk(clk), .reset(rst0), .bb(bi0));
  button_bounce_gen #(.BOUNCE_GLITCHES(G), .MAX_BOUNCE_CYCLES(M), .HOLD_CYCLES(H),
                      .RANDOM(1), .LFSR_SEED(SEED)) dut_rnd (.clk(clk), .reset(rst1), .bb(bi1));

  typedef struct {
    int         len;
    logic [63:0] wave;
    logic       tgt;
    bit         glitchy;
    int         off2;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          total = 0;
  int          bad   = 0;
  logic        m_btn  [2];
  logic [15:0] m_lfsr [2];
  bit          inf    [2];
  int          cyc    [2];
  logic [63:0] tr     [2];
  bit          hs_ok  [2];
  bit          chk_rdy[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ ((x & 16'd1) != 0 ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset(input int d);
    m_btn[d]  = 1'b0;
    m_lfsr[d] = SEED;
  endtask

  // Expected button per cycle after accept: index 1 is the first cycle, index len the done cycle.
  task automatic build(input int d, input logic tgt, output exp_t e);
    int pos = 1;
    int len_l;
    e.wave    = '0;
    e.tgt     = tgt;
    e.glitchy = (tgt != m_btn[d]) && (G > 0);
    e.off2    = 0;
    if (e.glitchy) begin
      for (int i = 0; i <= 2 * G; i++) begin
        len_l     = (d == 1) ? 1 + int'(m_lfsr[d] % M) : M;
        m_lfsr[d] = lfsr_step(m_lfsr[d]);
        if (i < 3) e.off2 += len_l;
        for (int k = 0; k < len_l; k++) begin
          e.wave[pos] = (i % 2 == 0) ? tgt : ~tgt;
          pos++;
        end
      end
    end
    for (int k = 0; k <= H; k++) begin
      e.wave[pos] = tgt;
      pos++;
    end
    e.len    = pos - 1;
    m_btn[d] = tgt;
  endtask

  task automatic mon(input int d, input logic rst, input logic st, input logic rdy,
                     input logic bsy, input logic dn, input logic btn);
    exp_t        e;
    int          tog;
    logic [63:0] mask;
    if (rst) begin
      inf[d]     = 0;
      chk_rdy[d] = 0;
      return;
    end
    if (chk_rdy[d]) begin
      check($sformatf("d%0d_ready_after_done", d), {62'd0, rdy, bsy}, 64'd2);
      chk_rdy[d] = 0;
    end
    if (inf[d]) begin
      cyc[d]++;
      if (cyc[d] < 64) tr[d][cyc[d]] = btn;
      if (!dn) begin
        if (!(bsy && !rdy)) hs_ok[d] = 0;
        if (cyc[d] >= 60) begin
          total++;
          bad++;
          $display("FAIL d%0d_done_timeout actual=no done after %0d cycles", d, cyc[d]);
          inf[d] = 0;
          if (d == 0 && q0.size() > 0) void'(q0.pop_front());
          if (d == 1 && q1.size() > 0) void'(q1.pop_front());
        end
      end else begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL d%0d_unexpected_done actual=done expected=empty scoreboard", d);
        end else begin
          e    = (d == 0) ? q0.pop_front() : q1.pop_front();
          mask = ((64'd1 << (e.len + 1)) - 64'd1) & ~64'd1;
          check($sformatf("d%0d_done_latency", d), 64'(cyc[d]), 64'(e.len));
          check($sformatf("d%0d_waveform", d), tr[d] & mask, e.wave & mask);
          check($sformatf("d%0d_busy_ready_during", d), {63'd0, hs_ok[d] & bsy & ~rdy}, 64'd1);
          check($sformatf("d%0d_first_edge", d), {63'd0, tr[d][1]}, {63'd0, e.tgt});
          tog = 0;
          for (int i = 2; i <= cyc[d] && i < 64; i++) if (tr[d][i] != tr[d][i-1]) tog++;
          check($sformatf("d%0d_toggles", d), 64'(tog), e.glitchy ? 64'(2 * G) : 64'd0);
        end
        inf[d]     = 0;
        chk_rdy[d] = 1;
      end
    end else if (dn) begin
      total++;
      bad++;
      $display("FAIL d%0d_spurious_done actual=1 expected=0", d);
    end
    if (st && rdy) begin
      inf[d]   = 1;
      cyc[d]   = 0;
      tr[d]    = '0;
      hs_ok[d] = 1;
    end
  endtask

  always @(negedge clk) begin
    mon(0, rst0, bi0.start, bi0.ready, bi0.busy, bi0.done, bi0.button);
    mon(1, rst1, bi1.start, bi1.ready, bi1.busy, bi1.done, bi1.button);
  end

  task automatic press(input int d, input logic lvl, output exp_t e);
    int n = 0;
    @(posedge clk); #1;
    while (!((d == 0) ? bi0.ready : bi1.ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL d%0d_ready_wait actual=ready low for %0d cycles", d, n);
      e = '{default: 0};
      return;
    end
    build(d, lvl, e);
    if (d == 0) begin
      q0.push_back(e);
      bi0.start = 1'b1;
      bi0.level = lvl;
    end else begin
      q1.push_back(e);
      bi1.start = 1'b1;
      bi1.level = lvl;
    end
    @(posedge clk); #1;
    if (d == 0) bi0.start = 1'b0;
    else        bi1.start = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (!(((d == 0) ? bi0.ready : bi1.ready) && ((d == 0) ? q0.size() : q1.size()) == 0)
           && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL d%0d_idle_wait actual=still busy after %0d cycles", d, n);
    end
  endtask

  exp_t e;
  logic lvl;

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    bi0.start = 1'b0;
    bi0.level = 1'b0;
    bi1.start = 1'b0;
    bi1.level = 1'b0;
    model_reset(0);
    model_reset(1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state_det", {60'd0, bi0.button, bi0.ready, bi0.busy, bi0.done}, 64'b0100);
    check("reset_state_rnd", {60'd0, bi1.button, bi1.ready, bi1.busy, bi1.done}, 64'b0100);
    rst0 = 1'b0;
    rst1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_quiet", {60'd0, bi0.button, bi0.ready, bi0.busy, bi0.done}, 64'b0100);
    end

    // Deterministic press, same-level repeat, then mirrored release.
    press(0, 1'b1, e);
    check("det_press_done_cycle", 64'(e.len), 64'(2 * G * M + M + H + 1));
    press(0, 1'b1, e);
    check("same_level_done_cycle", 64'(e.len), 64'(H + 1));
    press(0, 1'b0, e);
    wait_idle(0);

    // start pulses with level=0 during SEG_OFF (cycle 6) and HOLD (cycle 22) must be dropped.
    press(0, 1'b1, e);
    repeat (5) @(posedge clk);
    #1;
    bi0.start = 1'b1;
    bi0.level = 1'b0;
    @(posedge clk); #1;
    bi0.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    bi0.start = 1'b1;
    @(posedge clk); #1;
    bi0.start = 1'b0;
    wait_idle(0);
    repeat (4) @(posedge clk);
    #1;
    check("ignored_start_level", {63'd0, bi0.button}, 64'd1);

    // Randomized segment lengths.
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      lvl = 1'($urandom_range(0, 1));
      press(1, lvl, e);
    end
    wait_idle(1);

    // Abort during the second SEG_OFF, then replay from the seed.
    press(1, ~m_btn[1], e);
    repeat (e.off2) @(posedge clk);
    #1;
    rst1 = 1'b1;
    q1.delete();
    model_reset(1);
    @(posedge clk); #1;
    check("midreset_state", {60'd0, bi1.button, bi1.ready, bi1.busy, bi1.done}, 64'b0100);
    rst1 = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("midreset_no_activity", {60'd0, bi1.button, bi1.ready, bi1.busy, bi1.done}, 64'b0100);
    press(1, 1'b1, e);
    press(1, 1'b0, e);
    wait_idle(1);

    check("det_scoreboard_drained", 64'(q0.size()), 64'd0);
    check("rnd_scoreboard_drained", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
